// File: rtl/alu_flags_unit.sv
// Flag register, carry feedback, branch-condition evaluation and a small flag LIFO
// sitting between the ALU, the CPU data bus and the microsequencer.
module alu_flags_unit #(
    parameter int p_data_width  = 16,
    parameter int p_flags_width = 5,
    parameter int p_stack_depth = 4
) (
    input  logic                     i_w_clk,
    input  logic                     i_w_rst,
    input  logic [p_flags_width-1:0] i_w_flags,
    input  logic                     i_w_flags_we,
    input  logic [p_flags_width-1:0] i_w_flags_mask,
    input  logic [1:0]               i_w_cmd,
    input  logic                     i_w_use_carry,
    input  logic [p_data_width-1:0]  i_w_bus,
    input  logic                     i_w_bus_ld,
    input  logic                     i_w_bus_oe,
    input  logic                     i_w_push,
    input  logic                     i_w_pop,
    input  logic                     i_w_err_clr,
    input  logic [3:0]               i_w_cond,
    output logic [p_flags_width-1:0] o_w_flags,
    output logic                     o_w_carry,
    output logic                     o_w_cond_true,
    output logic [p_data_width-1:0]  o_w_bus,
    output logic                     o_w_stack_full,
    output logic                     o_w_stack_empty,
    output logic                     o_r_stack_err
);

    localparam int CNT_W = $clog2(p_stack_depth + 1);
    localparam int IDX_W = $clog2(p_stack_depth);

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_CLC  = 2'd1;
    localparam logic [1:0] CMD_STC  = 2'd2;
    localparam logic [1:0] CMD_CMC  = 2'd3;

    logic [p_flags_width-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [p_flags_width-1:0] stack_q [p_stack_depth];

    logic             full, empty;
    logic             push_ok, pop_ok, push_err, pop_err;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             unused_bus_hi;

    assign full  = (cnt_q == CNT_W'(p_stack_depth));
    assign empty = (cnt_q == '0);

    // Simultaneous push and pop cancel each other: no transfer and no error.
    assign push_ok  = i_w_push & ~i_w_pop & ~full;
    assign pop_ok   = i_w_pop & ~i_w_push & ~empty;
    assign push_err = i_w_push & ~i_w_pop & full;
    assign pop_err  = i_w_pop & ~i_w_push & empty;

    assign wr_idx = IDX_W'(cnt_q);
    assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

    assign unused_bus_hi = ^(i_w_bus >> p_flags_width);

    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
        end else if (i_w_bus_ld) begin
            flags_d = i_w_bus[p_flags_width-1:0];
        end else if (i_w_flags_we) begin
            flags_d = (flags_q & ~i_w_flags_mask) | (i_w_flags & i_w_flags_mask);
        end else begin
            unique case (i_w_cmd)
                CMD_CLC:  flags_d[0] = 1'b0;
                CMD_STC:  flags_d[0] = 1'b1;
                CMD_CMC:  flags_d[0] = ~flags_q[0];
                CMD_NONE: flags_d    = flags_q;
                default:  flags_d    = flags_q;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A fresh error on the clear cycle keeps the sticky bit set.
    always_comb begin
        err_d = (err_q & ~i_w_err_clr) | push_err | pop_err;
    end

    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // LIFO storage needs no reset; the count alone defines which entries are valid.
    always_ff @(posedge i_w_clk) begin
        if (push_ok) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    logic f_p, f_s, f_z, f_o, f_c, s_xor_o;
    assign f_p     = flags_q[4];
    assign f_s     = flags_q[3];
    assign f_z     = flags_q[2];
    assign f_o     = flags_q[1];
    assign f_c     = flags_q[0];
    assign s_xor_o = f_s ^ f_o;

    always_comb begin
        o_w_cond_true = 1'b0;
        unique case (i_w_cond)
            4'h0: o_w_cond_true = f_o;
            4'h1: o_w_cond_true = ~f_o;
            4'h2: o_w_cond_true = f_c;
            4'h3: o_w_cond_true = ~f_c;
            4'h4: o_w_cond_true = f_z;
            4'h5: o_w_cond_true = ~f_z;
            4'h6: o_w_cond_true = f_c | f_z;
            4'h7: o_w_cond_true = ~(f_c | f_z);
            4'h8: o_w_cond_true = f_s;
            4'h9: o_w_cond_true = ~f_s;
            4'hA: o_w_cond_true = f_p;
            4'hB: o_w_cond_true = ~f_p;
            4'hC: o_w_cond_true = s_xor_o;
            4'hD: o_w_cond_true = ~s_xor_o;
            4'hE: o_w_cond_true = f_z | s_xor_o;
            4'hF: o_w_cond_true = ~(f_z | s_xor_o);
            default: o_w_cond_true = 1'b0;
        endcase
    end

    assign o_w_flags       = flags_q;
    assign o_w_carry       = f_c & i_w_use_carry;
    assign o_w_bus         = i_w_bus_oe ? p_data_width'(flags_q) : '0;
    assign o_w_stack_full  = full;
    assign o_w_stack_empty = empty;
    assign o_r_stack_err   = err_q;

endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed-vector bench for alu_flags_unit with immediate-assertion checks.
module tb_alu_flags_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  flags_in, mask;
    logic        we, use_carry, bus_ld, bus_oe, push, pop, err_clr;
    logic [1:0]  cmd;
    logic [15:0] bus_in;
    logic [3:0]  cond;
    logic [4:0]  flags_out;
    logic        carry, cond_true, full, empty, err;
    logic [15:0] bus_out;

    int checks = 0;
    int errors = 0;

    alu_flags_unit dut (
        .i_w_clk(clk), .i_w_rst(rst),
        .i_w_flags(flags_in), .i_w_flags_we(we), .i_w_flags_mask(mask),
        .i_w_cmd(cmd), .i_w_use_carry(use_carry),
        .i_w_bus(bus_in), .i_w_bus_ld(bus_ld), .i_w_bus_oe(bus_oe),
        .i_w_push(push), .i_w_pop(pop), .i_w_err_clr(err_clr), .i_w_cond(cond),
        .o_w_flags(flags_out), .o_w_carry(carry), .o_w_cond_true(cond_true),
        .o_w_bus(bus_out), .o_w_stack_full(full), .o_w_stack_empty(empty),
        .o_r_stack_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flags_in = '0; mask = '0; we = 0; cmd = 2'd0; use_carry = 0;
        bus_in = '0; bus_ld = 0; bus_oe = 0; push = 0; pop = 0; err_clr = 0; cond = '0;
    endtask

    // Inputs are idle during the sweep, so state holds even if an edge passes.
    task automatic cond_sweep(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            got[i] = cond_true;
        end
        chk(tag, got, exp);
        cond = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk("rst_flags", 16'(flags_out), 16'h0000);
        chk("rst_empty", 16'(empty), 16'h1);
        chk("rst_full", 16'(full), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_bus", bus_out, 16'h0000);
        use_carry = 1; #1;
        chk("rst_carry", 16'(carry), 16'h0);
        use_carry = 0;
        cond_sweep("rst_conds", 16'hAAAA);
        rst = 1'b0;
        tick();

        // full-mask write, then condition check
        we = 1; mask = 5'b11111; flags_in = 5'b01001;
        tick();
        idle();
        chk("we_full", 16'(flags_out), 16'h0009);
        cond_sweep("conds_01001", 16'h5966);

        // async reset mid-stream after two pushes
        push = 1; tick(); tick(); push = 0;
        chk("two_push_empty", 16'(empty), 16'h0);
        rst = 1'b1; #2;
        chk("arst_flags", 16'(flags_out), 16'h0000);
        chk("arst_empty", 16'(empty), 16'h1);
        chk("arst_full", 16'(full), 16'h0);
        chk("arst_err", 16'(err), 16'h0);
        cond = 4'hF; #1;
        chk("arst_condF", 16'(cond_true), 16'h1);
        cond = '0;
        rst = 1'b0;
        tick();

        // masked write and carry commands
        we = 1; mask = 5'b11111; flags_in = 5'b00001; tick();
        mask = 5'b11110; flags_in = 5'b11110; tick();
        idle();
        chk("masked_we", 16'(flags_out), 16'h001F);
        use_carry = 1; #1;
        chk("carry_pass", 16'(carry), 16'h1);
        use_carry = 0; #1;
        chk("carry_forced0", 16'(carry), 16'h0);
        cmd = 2'd3; tick(); cmd = 2'd0;
        chk("cmc", 16'(flags_out), 16'h001E);
        use_carry = 1; #1;
        chk("carry_after_cmc", 16'(carry), 16'h0);
        use_carry = 0;
        cmd = 2'd2; tick();
        chk("stc", 16'(flags_out), 16'h001F);
        cmd = 2'd1; tick(); cmd = 2'd0;
        chk("clc", 16'(flags_out), 16'h001E);

        // fill the LIFO: each push saves the pre-edge flags while bus_ld loads the next value
        bus_ld = 1; bus_in = 16'h0001; tick();
        push = 1; bus_in = 16'h0002; tick();
        bus_in = 16'h0004; tick();
        bus_in = 16'h0008; tick();
        bus_ld = 0; tick();
        push = 0;
        chk("fill_full", 16'(full), 16'h1);
        chk("fill_err", 16'(err), 16'h0);
        push = 1; tick(); push = 0;
        chk("overflow_err", 16'(err), 16'h1);
        chk("overflow_full", 16'(full), 16'h1);
        pop = 1; tick();
        chk("pop1", 16'(flags_out), 16'h0008);
        tick();
        chk("pop2", 16'(flags_out), 16'h0004);
        tick();
        chk("pop3", 16'(flags_out), 16'h0002);
        tick();
        chk("pop4", 16'(flags_out), 16'h0001);
        chk("pop4_empty", 16'(empty), 16'h1);
        tick(); pop = 0;
        chk("underflow_flags", 16'(flags_out), 16'h0001);
        chk("underflow_err", 16'(err), 16'h1);

        // pop on empty lets the bus load through; error stays set through a clear that collides
        pop = 1; bus_ld = 1; bus_in = 16'h0015; err_clr = 1; tick();
        idle();
        chk("empty_pop_busld", 16'(flags_out), 16'h0015);
        chk("clr_collide_err", 16'(err), 16'h1);
        err_clr = 1; tick(); err_clr = 0;
        chk("err_clr", 16'(err), 16'h0);

        // pop wins over bus_ld and we
        push = 1; tick(); push = 0;
        bus_ld = 1; bus_in = 16'h0000; tick();
        pop = 1; bus_in = 16'h001F; we = 1; mask = 5'b11111; flags_in = 5'b11111; tick();
        idle();
        chk("pop_priority", 16'(flags_out), 16'h0015);
        chk("pop_priority_empty", 16'(empty), 16'h1);
        cond_sweep("conds_10101", 16'h6656);

        // push+pop cancel, lower-priority load still applies
        push = 1; tick();
        pop = 1; bus_ld = 1; bus_in = 16'h0003; tick();
        idle();
        chk("pp_flags", 16'(flags_out), 16'h0003);
        chk("pp_empty", 16'(empty), 16'h0);
        chk("pp_full", 16'(full), 16'h0);
        chk("pp_err", 16'(err), 16'h0);
        pop = 1; tick(); pop = 0;
        chk("pp_then_pop", 16'(flags_out), 16'h0015);
        chk("pp_then_pop_empty", 16'(empty), 16'h1);

        // bus output and bus load with upper bits set
        bus_oe = 1; #1;
        chk("bus_oe", bus_out, 16'h0015);
        bus_ld = 1; bus_in = 16'hFFEA; tick(); bus_ld = 0;
        chk("bus_ld_flags", 16'(flags_out), 16'h000A);
        chk("bus_oe_new", bus_out, 16'h000A);
        bus_oe = 0; #1;
        chk("bus_off", bus_out, 16'h0000);
        cond_sweep("conds_01010", 16'hA9A9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
